branch_resolve_ctrl: RTL and testbench

//  Decode-stage branch sequencer. Waits for forwarded branch operands, evaluates the MIPS branch condition,
//  and issues a one-shot PC redirect to IF over a valid/ready handshake. Drives the ID stall.

---
 rtl/branch_resolve_ctrl_pkg.sv | 30 +++
 rtl/branch_resolve_ctrl_if.sv | 24 ++
 rtl/branch_resolve_ctrl_br_cond_eval.sv | 43 ++++
 rtl/branch_resolve_ctrl.sv | 159 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the decode-stage branch sequencer: MIPS branch
// opcodes, REGIMM rt sub-op codes, the sequencer state encoding and a
// small helper for recognising the linking REGIMM branches.
package branch_resolve_ctrl_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BRS_IDLE = 2'd0,
        BRS_WAIT = 2'd1,
        BRS_HOLD = 2'd2
    } brs_state_t;

    // True for the REGIMM sub-ops that write the link register.
    function automatic logic rt_is_link(input logic [4:0] rt);
        return (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Redirect channel from the branch sequencer to IF.
// Handshake: the master raises redirect_valid with redirect_pc and keeps
// both stable until a cycle in which redirect_ready is also high; the
// transfer completes on that rising clock edge. The slave may hold
// redirect_ready high without waiting for valid.
interface branch_resolve_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_resolve_ctrl_br_cond_eval.sv
// Combinational MIPS branch condition evaluation. Unknown opcodes or
// REGIMM sub-ops evaluate as not taken so the sequencer still resolves them.
module br_cond_eval
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              taken,
    output logic              link
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = a[DATA_W-1];
    assign a_zero = (a == '0);

    // Decode the branch type and evaluate its condition on the operands.
    always_comb begin
        taken = 1'b0;
        link  = 1'b0;
        case (op)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BGTZ: taken = ~a_neg & ~a_zero;
            OP_BLEZ: taken = a_neg | a_zero;
            OP_REGIMM: begin
                link = rt_is_link(rt);
                case (rt)
                    RT_BLTZ, RT_BLTZAL: taken = a_neg;
                    RT_BGEZ, RT_BGEZAL: taken = ~a_neg;
                    default:            taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch sequencer: waits for forwarded operands, resolves
// the branch, and issues a one-shot PC redirect to IF. Drives the ID stall.
// Optional feature: define BR_STATS_EN to build the resolved/taken
// branch counters; otherwise br_total and br_taken read as zero.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  br_req,
    input  logic [5:0]            br_op,
    input  logic [4:0]            br_rt,
    input  logic [DATA_W-1:0]     opnd_a,
    input  logic [DATA_W-1:0]     opnd_b,
    input  logic                  opnd_ready,
    input  logic [ADDR_W-1:0]     br_target,
    output logic                  stall_id,
    output logic                  resolve,
    output logic                  is_link,
    branch_resolve_ctrl_if.master redir,
    output logic [WAIT_CNT_W-1:0] wait_cnt,
    output logic [31:0]           br_total,
    output logic [31:0]           br_taken,
    output logic [1:0]            state_dbg
);

    brs_state_t state, state_nxt;

    logic cond_taken;
    logic cond_link;
    logic load_redir;
    logic clr_redir;
    logic cnt_inc;
    logic cnt_clr;

    br_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .op    (br_op),
        .rt    (br_rt),
        .a     (opnd_a),
        .b     (opnd_b),
        .taken (cond_taken),
        .link  (cond_link)
    );

    assign is_link   = resolve & cond_link;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= BRS_IDLE;
        else         state <= state_nxt;
    end

    // Next state, stall/resolve outputs and datapath strobes; flush overrides everything.
    always_comb begin
        state_nxt  = state;
        stall_id   = 1'b0;
        resolve    = 1'b0;
        load_redir = 1'b0;
        clr_redir  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        if (flush) begin
            state_nxt = BRS_IDLE;
            clr_redir = 1'b1;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                BRS_IDLE: begin
                    if (br_req) begin
                        if (opnd_ready) begin
                            resolve = 1'b1;
                            if (cond_taken) begin
                                load_redir = 1'b1;
                                state_nxt  = BRS_HOLD;
                            end
                        end else begin
                            // The first stalled cycle already counts as waiting.
                            stall_id  = 1'b1;
                            cnt_inc   = 1'b1;
                            state_nxt = BRS_WAIT;
                        end
                    end
                end
                BRS_WAIT: begin
                    if (!br_req) begin
                        cnt_clr   = 1'b1;
                        state_nxt = BRS_IDLE;
                    end else if (opnd_ready) begin
                        resolve = 1'b1;
                        cnt_clr = 1'b1;
                        if (cond_taken) begin
                            load_redir = 1'b1;
                            state_nxt  = BRS_HOLD;
                        end else begin
                            state_nxt = BRS_IDLE;
                        end
                    end else begin
                        stall_id = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                end
                BRS_HOLD: begin
                    // A branch in the delay slot waits until the redirect is taken.
                    stall_id = br_req;
                    if (redir.redirect_ready) begin
                        clr_redir = 1'b1;
                        state_nxt = BRS_IDLE;
                    end
                end
                default: state_nxt = BRS_IDLE;
            endcase
        end
    end

    // Redirect request register: loaded on a taken resolve, dropped on acceptance or flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir.redirect_valid <= 1'b0;
            redir.redirect_pc    <= '0;
        end else if (load_redir) begin
            redir.redirect_valid <= 1'b1;
            redir.redirect_pc    <= br_target;
        end else if (clr_redir) begin
            redir.redirect_valid <= 1'b0;
        end
    end

    // Saturating count of cycles the current branch has waited for operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 wait_cnt <= '0;
        else if (cnt_clr)            wait_cnt <= '0;
        else if (cnt_inc && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
    end

`ifdef BR_STATS_EN
    // Resolved and taken branch counters, free-running with 32-bit wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_total <= '0;
            br_taken <= '0;
        end else if (resolve) begin
            br_total <= br_total + 32'd1;
            if (cond_taken) br_taken <= br_taken + 32'd1;
        end
    end
`else
    assign br_total = ZERO_WORD;
    assign br_taken = ZERO_WORD;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: table of single-cycle resolves plus
// hand-written multi-cycle sequences; redirect targets checked through an
// expected queue popped on each completed redirect handshake.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        br_req;
    logic [5:0]  br_op;
    logic [4:0]  br_rt;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic        opnd_ready;
    logic [31:0] br_target;
    logic        stall_id;
    logic        resolve;
    logic        is_link;
    logic [3:0]  wait_cnt;
    logic [31:0] br_total;
    logic [31:0] br_taken;
    logic [1:0]  state_dbg;

    branch_resolve_ctrl_if #(.ADDR_W(32)) rif ();

    branch_resolve_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .WAIT_CNT_W (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .br_req     (br_req),
        .br_op      (br_op),
        .br_rt      (br_rt),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .opnd_ready (opnd_ready),
        .br_target  (br_target),
        .stall_id   (stall_id),
        .resolve    (resolve),
        .is_link    (is_link),
        .redir      (rif.master),
        .wait_cnt   (wait_cnt),
        .br_total   (br_total),
        .br_taken   (br_taken),
        .state_dbg  (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int exp_total = 0;
    int exp_taken = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic        link;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input logic [5:0] op, input logic [4:0] rt,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic t, input logic l);
        vec_t v;
        v.name = n; v.op = op; v.rt = rt; v.a = a; v.b = b; v.taken = t; v.link = l;
        vq.push_back(v);
    endtask

    task automatic set_br(input logic [5:0] op, input logic [4:0] rt,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
        br_op = op; br_rt = rt; opnd_a = a; opnd_b = b; br_target = tgt;
    endtask

    // Redirect monitor: every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (resetn && !flush && rif.redirect_valid && rif.redirect_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL redir_unexpected: got pc 0x%0h expected no redirect", rif.redirect_pc);
            end else begin
                chk("redir_pc", rif.redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] t1;

        resetn = 1'b0; flush = 1'b0; br_req = 1'b0; opnd_ready = 1'b0;
        rif.redirect_ready = 1'b0;
        set_br(6'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        add_vec("beq_eq",    OP_BEQ,    5'd0,      32'd5,         32'd5, 1'b1, 1'b0);
        add_vec("beq_ne",    OP_BEQ,    5'd0,      32'd5,         32'd6, 1'b0, 1'b0);
        add_vec("bne_eq",    OP_BNE,    5'd0,      32'd5,         32'd5, 1'b0, 1'b0);
        add_vec("bne_ne",    OP_BNE,    5'd0,      32'd5,         32'd6, 1'b1, 1'b0);
        add_vec("bgtz_pos",  OP_BGTZ,   5'd0,      32'd1,         32'd0, 1'b1, 1'b0);
        add_vec("bgtz_zero", OP_BGTZ,   5'd0,      32'd0,         32'd0, 1'b0, 1'b0);
        add_vec("bgtz_neg",  OP_BGTZ,   5'd0,      32'h8000_0000, 32'd0, 1'b0, 1'b0);
        add_vec("blez_zero", OP_BLEZ,   5'd0,      32'd0,         32'd0, 1'b1, 1'b0);
        add_vec("blez_neg",  OP_BLEZ,   5'd0,      32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        add_vec("blez_pos",  OP_BLEZ,   5'd0,      32'd7,         32'd0, 1'b0, 1'b0);
        add_vec("bltz_neg",  OP_REGIMM, RT_BLTZ,   32'h8000_0000, 32'd0, 1'b1, 1'b0);
        add_vec("bltz_pos",  OP_REGIMM, RT_BLTZ,   32'd3,         32'd0, 1'b0, 1'b0);
        add_vec("bgez_zero", OP_REGIMM, RT_BGEZ,   32'd0,         32'd0, 1'b1, 1'b0);
        add_vec("bgez_neg",  OP_REGIMM, RT_BGEZ,   32'hF000_0000, 32'd0, 1'b0, 1'b0);
        add_vec("bltzal_t",  OP_REGIMM, RT_BLTZAL, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b1);
        add_vec("bgezal_nt", OP_REGIMM, RT_BGEZAL, 32'h8000_0001, 32'd0, 1'b0, 1'b1);
        add_vec("bad_op",    6'b000000, 5'd0,      32'd5,         32'd5, 1'b0, 1'b0);
        add_vec("bad_rt",    OP_REGIMM, 5'b00010,  32'h8000_0000, 32'd0, 1'b0, 1'b0);

        // Reset state.
        #12;
        chk("rst_state", 32'(state_dbg), 32'(BRS_IDLE));
        chk("rst_valid", 32'(rif.redirect_valid), 32'd0);
        chk("rst_pc", rif.redirect_pc, 32'd0);
        chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);
        chk("rst_total", br_total, 32'd0);
        chk("rst_taken", br_taken, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Table: operands ready, IF always ready.
        rif.redirect_ready = 1'b1;
        foreach (vq[i]) begin
            set_br(vq[i].op, vq[i].rt, vq[i].a, vq[i].b, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            br_req = 1'b1; opnd_ready = 1'b1;
            #1;
            chk({vq[i].name, "_resolve"}, 32'(resolve), 32'd1);
            chk({vq[i].name, "_stall"}, 32'(stall_id), 32'd0);
            chk({vq[i].name, "_link"}, 32'(is_link), 32'(vq[i].link));
            exp_total++;
            if (vq[i].taken) begin
                exp_taken++;
                exp_q.push_back(br_target);
            end
            tick();
            br_req = 1'b0;
            chk({vq[i].name, "_valid"}, 32'(rif.redirect_valid), 32'(vq[i].taken));
            if (vq[i].taken) begin
                tick();
                chk({vq[i].name, "_valid_drop"}, 32'(rif.redirect_valid), 32'd0);
            end
            chk({vq[i].name, "_idle"}, 32'(state_dbg), 32'(BRS_IDLE));
        end

        // BGTZ waiting three cycles for its operand.
        set_br(OP_BGTZ, 5'd0, 32'd1, 32'd0, 32'h0040_1000);
        br_req = 1'b1; opnd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("wait_stall", 32'(stall_id), 32'd1);
            chk("wait_noresolve", 32'(resolve), 32'd0);
            tick();
            chk("wait_cnt_step", 32'(wait_cnt), 32'(c + 1));
        end
        chk("wait_state", 32'(state_dbg), 32'(BRS_WAIT));
        opnd_ready = 1'b1;
        #1;
        chk("wait_resolve", 32'(resolve), 32'd1);
        chk("wait_resolve_stall", 32'(stall_id), 32'd0);
        exp_total++; exp_taken++;
        exp_q.push_back(br_target);
        tick();
        br_req = 1'b0;
        chk("wait_redir_valid", 32'(rif.redirect_valid), 32'd1);
        chk("wait_cnt_clr", 32'(wait_cnt), 32'd0);
        tick();

        // Redirect held four cycles; BGEZ in the delay slot stalls until IDLE.
        rif.redirect_ready = 1'b0;
        t1 = 32'h0080_2000;
        set_br(OP_BEQ, 5'd0, 32'd5, 32'd5, t1);
        br_req = 1'b1; opnd_ready = 1'b1;
        exp_total++; exp_taken++;
        exp_q.push_back(t1);
        tick();
        set_br(OP_REGIMM, RT_BGEZ, 32'h8000_0000, 32'd0, 32'h0DEA_D000);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold_stall", 32'(stall_id), 32'd1);
            chk("hold_noresolve", 32'(resolve), 32'd0);
            chk("hold_pc", rif.redirect_pc, t1);
            chk("hold_valid", 32'(rif.redirect_valid), 32'd1);
            tick();
        end
        rif.redirect_ready = 1'b1;
        tick();
        chk("hold_back_idle", 32'(state_dbg), 32'(BRS_IDLE));
        chk("slot_resolve", 32'(resolve), 32'd1);
        chk("slot_stall", 32'(stall_id), 32'd0);
        exp_total++;
        br_req = 1'b0;
        tick();
        chk("slot_no_redirect", 32'(rif.redirect_valid), 32'd0);

        // WAIT abandoned when br_req drops.
        br_req = 1'b1; opnd_ready = 1'b0;
        tick();
        br_req = 1'b0;
        #1;
        chk("drop_stall", 32'(stall_id), 32'd0);
        tick();
        chk("drop_state", 32'(state_dbg), 32'(BRS_IDLE));
        chk("drop_wait_cnt", 32'(wait_cnt), 32'd0);
        chk("drop_valid", 32'(rif.redirect_valid), 32'd0);

        // Wait counter saturates.
        br_req = 1'b1; opnd_ready = 1'b0;
        repeat (18) tick();
        chk("sat_wait_cnt", 32'(wait_cnt), 32'd15);

        // Flush while waiting.
        flush = 1'b1;
        #1;
        chk("flushw_stall", 32'(stall_id), 32'd0);
        chk("flushw_resolve", 32'(resolve), 32'd0);
        tick();
        flush = 1'b0; br_req = 1'b0;
        chk("flushw_state", 32'(state_dbg), 32'(BRS_IDLE));
        chk("flushw_wait_cnt", 32'(wait_cnt), 32'd0);

        // Flush in HOLD together with redirect_ready: redirect dropped.
        rif.redirect_ready = 1'b0;
        set_br(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h0BAD_0000);
        br_req = 1'b1; opnd_ready = 1'b1;
        exp_total++; exp_taken++;
        tick();
        br_req = 1'b0;
        chk("flushh_pre_state", 32'(state_dbg), 32'(BRS_HOLD));
        flush = 1'b1; rif.redirect_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushh_state", 32'(state_dbg), 32'(BRS_IDLE));
        chk("flushh_valid", 32'(rif.redirect_valid), 32'd0);
        tick();

        // Statistics (zero unless the counters are built).
`ifdef BR_STATS_EN
        chk("stat_total", br_total, 32'(exp_total));
        chk("stat_taken", br_taken, 32'(exp_taken));
`else
        chk("stat_total", br_total, 32'd0);
        chk("stat_taken", br_taken, 32'd0);
`endif

        // Asynchronous reset with a redirect pending.
        rif.redirect_ready = 1'b0;
        set_br(OP_BEQ, 5'd0, 32'd9, 32'd9, 32'h0123_4560);
        br_req = 1'b1; opnd_ready = 1'b1;
        tick();
        chk("arst_pre_valid", 32'(rif.redirect_valid), 32'd1);
        resetn = 1'b0; br_req = 1'b0;
        #1;
        chk("arst_valid", 32'(rif.redirect_valid), 32'd0);
        chk("arst_pc", rif.redirect_pc, 32'd0);
        chk("arst_state", 32'(state_dbg), 32'(BRS_IDLE));
        chk("arst_total", br_total, 32'd0);
        tick();
        resetn = 1'b1;
        rif.redirect_ready = 1'b1;
        repeat (2) tick();
        chk("arst_no_redirect", 32'(rif.redirect_valid), 32'd0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
